// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: FSM states, op codes, default I/O address.
package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_DONE = ST_DONE
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam logic [7:0] DEF_IO_ADDR = 8'hFF;

endpackage

// File: rtl/mem_array.sv
// Word array: one synchronous write port, one asynchronous read port. Never reset.
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // single write port, contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// one I/O byte at IO_ADDR, and a host loader port usable while idle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int            AW          = 8,
  parameter int            DW          = 8,
  parameter int            WAIT_CYCLES = 1,
  parameter logic [AW-1:0] IO_ADDR     = AW'(DEF_IO_ADDR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          rden,
  input  logic          wren,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy,
  output logic          err,
  input  logic [DW-1:0] io_in,
  output logic [DW-1:0] io_out,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          load_rdy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          accept, conflict, enter_done;
  logic          acc_op;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          is_io, cpu_we, io_we, rd_done, load_go;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [DW-1:0] arr_wdata, arr_rdata;

  // next-state: requests are only looked at in IDLE
  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    conflict  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rden && wren) begin
          conflict = 1'b1;
        end else if (rden || wren) begin
          accept    = 1'b1;
          nxt_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT:  if (cnt == '0) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge itself,
  // before the request has been latched, so take the live inputs in IDLE.
  assign acc_op     = (state == S_IDLE) ? (wren ? OP_WR : OP_RD) : op_q;
  assign acc_addr   = (state == S_IDLE) ? addr  : addr_q;
  assign acc_wdata  = (state == S_IDLE) ? wdata : wdata_q;
  assign enter_done = (nxt_state == S_DONE) && (state != S_DONE);
  assign is_io      = (acc_addr == IO_ADDR);
  assign cpu_we     = enter_done && (acc_op == OP_WR) && !is_io;
  assign io_we      = enter_done && (acc_op == OP_WR) &&  is_io;
  assign rd_done    = enter_done && (acc_op == OP_RD);

  assign load_rdy = (state == S_IDLE) && !rden && !wren;
  assign load_go  = load_we && load_rdy;

  // CPU and loader never overlap (load_rdy excludes any pending request)
  assign arr_we    = cpu_we || load_go;
  assign arr_waddr = cpu_we ? acc_addr  : load_addr;
  assign arr_wdata = cpu_we ? acc_wdata : load_data;

  mem_array #(.AW(AW), .DW(DW)) u_arr (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (acc_addr),
    .rdata (arr_rdata)
  );

  // state register and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        op_q    <= wren ? OP_WR : OP_RD;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // wait-state counter: loaded on accept, counts down in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (accept)                           cnt <= CNT_INIT;
    else if (state == S_WAIT && cnt != '0)     cnt <= cnt - 1'b1;
  end

  // registered status outputs and data results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      io_out <= '0;
    end else begin
      ack  <= enter_done;
      busy <= (nxt_state != S_IDLE);
      err  <= conflict;
      if (io_we)   io_out <= acc_wdata;
      if (rd_done) rdata  <= is_io ? io_in : arr_rdata;
    end
  end

endmodule
